// File: rtl/mips_pkg.sv
// Shared definitions for the fetch front end: the nop encoding, the default boot PC
// and the entry type held in the prefetch queue.
package mips_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch queue: synchronous FIFO of fetched {pc, inst} pairs with a single-cycle
// flush used when the fetch stream is redirected.
module if_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t dout,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A flush wins over any same-cycle push or pop.
  assign do_pop  = pop  && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: owns the fetch PC, runs req/ack reads into a small prefetch
// queue and hands a valid/ready instruction stream to decode; redirects flush the queue.
module if_prefetch
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]  fpc;
  logic         pending;
  logic         drop;

  fetch_entry_t head;
  fetch_entry_t new_entry;
  logic [AW:0]  count;
  logic         empty;
  logic         full;

  logic         ack_ok;
  logic         outstanding;
  logic         push;
  logic         pop;

  // A read that has been issued stays requested until acked; a new read only starts
  // when the queue has room, so an acked word always has a slot to land in.
  assign imem_req    = !rst && (pending || (count < DEPTH_C));
  assign imem_addr   = fpc;

  assign ack_ok      = imem_req && imem_ack;
  assign outstanding = imem_req && !imem_ack;

  assign inst_valid  = !rst && !empty;
  assign pop         = inst_valid && inst_ready && !redirect;
  assign push        = ack_ok && !drop && !redirect && (!full || pop);

  assign new_entry.pc   = fpc;
  assign new_entry.inst = imem_rdata;

  // ---- fetch control: PC, outstanding-read and discard tracking ----
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc     <= RESET_PC;
      pending <= 1'b0;
      drop    <= 1'b0;
    end else begin
      pending <= outstanding;
      if (redirect) begin
        fpc  <= word_align(redirect_pc);
        // The read still in flight belongs to the old path; its ack must be thrown away.
        drop <= outstanding;
      end else if (ack_ok) begin
        if (!drop) fpc <= fpc + 32'd4;
        drop <= 1'b0;
      end
    end
  end

  // ---- prefetch queue ----
  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .din   (new_entry),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // ---- decode-facing outputs, zeroed while nothing valid is presented ----
  assign inst     = inst_valid ? head.inst        : NOP;
  assign inst_pc  = inst_valid ? head.pc          : 32'h0;
  assign pc_plus4 = inst_valid ? head.pc + 32'd4  : 32'h0;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a req/ack memory with configurable wait states, directed
// scenarios with literal expectations, and a queue-based reference checked every cycle.
module tb_if_prefetch;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc_plus4    (pc_plus4)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Instruction memory: latches the address when a request starts, acks after m_target waits.
  int          wait_states = 0;
  bit          rand_wait   = 1'b0;
  bit          m_busy      = 1'b0;
  logic [31:0] m_lat       = '0;
  int          m_wait      = 0;
  int          m_target    = 0;
  int          acks_total  = 0;
  logic [31:0] start_log[$];

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!m_busy && imem_req === 1'b1) begin
        m_busy   = 1'b1;
        m_lat    = imem_addr;
        m_wait   = 0;
        m_target = rand_wait ? int'($urandom_range(0, 3)) : wait_states;
        start_log.push_back(imem_addr);
      end
      if (m_busy && m_wait >= m_target) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(m_lat);
        m_busy     = 1'b0;
        if (imem_req === 1'b1) acks_total++;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (m_busy) m_wait++;
      end
    end
  end

  // Reference: a queue of fetched words plus the fetch PC and in-flight/discard flags.
  fetch_entry_t q[$];
  logic [31:0]  m_fpc      = 32'h0;
  bit           m_inflight = 1'b0;
  bit           m_discard  = 1'b0;
  logic [31:0]  pop_log[$];

  always @(negedge clk) begin
    bit           er;
    bit           ev;
    fetch_entry_t h;
    er = !rst && (m_inflight || q.size() < DEPTH);
    ev = !rst && (q.size() > 0);
    h  = (q.size() > 0) ? q[0] : '0;
    chk("imem_req", {31'b0, imem_req}, {31'b0, er});
    if (er) chk("imem_addr", imem_addr, m_fpc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, ev});
    chk("inst",     inst,     ev ? h.inst : 32'h0);
    chk("inst_pc",  inst_pc,  ev ? h.pc : 32'h0);
    chk("pc_plus4", pc_plus4, ev ? h.pc + 32'd4 : 32'h0);
    if (inst_valid === 1'b1 && inst_ready && !redirect && !rst) pop_log.push_back(inst_pc);

    if (rst) begin
      q.delete();
      m_fpc      = 32'h0;
      m_inflight = 1'b0;
      m_discard  = 1'b0;
    end else begin
      if (redirect) begin
        q.delete();
        m_discard = er && !imem_ack;
        m_fpc     = {redirect_pc[31:2], 2'b00};
      end else begin
        if (ev && inst_ready) void'(q.pop_front());
        if (er && imem_ack) begin
          if (!m_discard) begin
            q.push_back('{pc: m_fpc, inst: imem_rdata});
            m_fpc = m_fpc + 32'd4;
          end
          m_discard = 1'b0;
        end
      end
      m_inflight = er && !imem_ack;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    redirect = 1'b0;
    repeat (n) next_cycle();
    rst = 1'b0;
  endtask

  task automatic wait_read_of(input logic [31:0] a, output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_busy && m_lat == a) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
  endtask

  initial begin
    bit found;
    int bad;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;

    // 1: 0-wait memory, stream one instruction per cycle
    wait_states = 0;
    inst_ready  = 1'b1;
    do_reset(2);
    #3;
    chk("t1_req", {31'b0, imem_req}, 32'h1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid_first", {31'b0, inst_valid}, 32'h0);
    next_cycle(); #3;
    chk("t1_valid", {31'b0, inst_valid}, 32'h1);
    chk("t1_pc0", inst_pc, 32'h0);
    chk("t1_inst0", inst, 32'hC0DE_0000);
    chk("t1_pc4_0", pc_plus4, 32'h4);
    chk("t1_addr4", imem_addr, 32'h4);
    next_cycle(); #3;
    chk("t1_pc1", inst_pc, 32'h4);
    next_cycle(); #3;
    chk("t1_pc2", inst_pc, 32'h8);

    // 2: decode stalled: queue fills to DEPTH then requests stop
    inst_ready = 1'b0;
    do_reset(5);
    bad = acks_total;
    repeat (10) next_cycle();
    #3;
    chk("t2_acks", acks_total - bad, 32'd4);
    chk("t2_req_off", {31'b0, imem_req}, 32'h0);
    pop_log.delete();
    inst_ready = 1'b1;
    repeat (8) next_cycle();
    chk("t2_npop", {31'b0, pop_log.size() >= 5}, 32'h1);
    for (int i = 0; i < 5 && i < pop_log.size(); i++)
      chk("t2_order", pop_log[i], 32'(4 * i));

    // 3: redirect to an unaligned target with 3 entries queued
    inst_ready = 1'b0;
    do_reset(5);
    repeat (3) next_cycle();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    #3;
    chk("t3_valid_before", {31'b0, inst_valid}, 32'h1);
    next_cycle();
    redirect = 1'b0;
    #3;
    chk("t3_valid_flushed", {31'b0, inst_valid}, 32'h0);
    chk("t3_addr", imem_addr, 32'h100);
    inst_ready = 1'b1;
    next_cycle(); #3;
    chk("t3_first_pc", inst_pc, 32'h100);
    chk("t3_first_inst", inst, 32'hC0DE_0100);

    // 4: 3-wait memory, redirect while the read of 0x8 is outstanding
    wait_states = 3;
    inst_ready  = 1'b1;
    do_reset(5);
    wait_read_of(32'h8, found);
    chk("t4_reach", {31'b0, found}, 32'h1);
    next_cycle();
    pop_log.delete();
    start_log.delete();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    next_cycle();
    redirect = 1'b0;
    repeat (20) next_cycle();
    chk("t4_nstart", {31'b0, start_log.size() > 0}, 32'h1);
    if (start_log.size() > 0) chk("t4_next_req", start_log[0], 32'h40);
    chk("t4_npop", {31'b0, pop_log.size() > 0}, 32'h1);
    if (pop_log.size() > 0) chk("t4_first_pc", pop_log[0], 32'h40);
    bad = 0;
    foreach (pop_log[i]) if (pop_log[i] == 32'h8) bad++;
    chk("t4_no_8", 32'(bad), 32'h0);

    // 5: redirect coinciding with an ack and a pop
    wait_states = 0;
    inst_ready  = 1'b1;
    do_reset(5);
    repeat (4) next_cycle();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #3;
    chk("t5_ack_same", {31'b0, imem_ack}, 32'h1);
    chk("t5_pop_same", {31'b0, inst_valid}, 32'h1);
    next_cycle();
    redirect = 1'b0;
    #3;
    chk("t5_empty", {31'b0, inst_valid}, 32'h0);
    chk("t5_addr", imem_addr, 32'h200);
    next_cycle(); #3;
    chk("t5_first_pc", inst_pc, 32'h200);

    // 6: reset with a read outstanding and 2 entries queued; the stale ack lands during reset
    wait_states = 3;
    inst_ready  = 1'b0;
    do_reset(5);
    wait_read_of(32'h8, found);
    chk("t6_reach", {31'b0, found}, 32'h1);
    chk("t6_valid_before", {31'b0, inst_valid}, 32'h1);
    rst = 1'b1;
    #3;
    chk("t6_req_rst", {31'b0, imem_req}, 32'h0);
    chk("t6_valid_rst", {31'b0, inst_valid}, 32'h0);
    chk("t6_inst_rst", inst, 32'h0);
    repeat (4) next_cycle();
    next_cycle();
    rst = 1'b0;
    #3;
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_valid", {31'b0, inst_valid}, 32'h0);
    chk("t6_pc", inst_pc, 32'h0);
    chk("t6_pc4", pc_plus4, 32'h0);
    pop_log.delete();
    inst_ready = 1'b1;
    repeat (12) next_cycle();
    chk("t6_npop", {31'b0, pop_log.size() > 0}, 32'h1);
    if (pop_log.size() > 0) chk("t6_restart_pc", pop_log[0], 32'h0);

    // Random traffic: variable wait states, stalls, redirects and occasional reset
    rand_wait = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      inst_ready  = ((i / 64) % 4 == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      rst         = ($urandom_range(0, 249) == 0);
    end
    next_cycle();
    rst = 1'b0;
    redirect = 1'b0;
    repeat (4) next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
